hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter TRAP_FLUSH_CYCLES, default 2, number of cycles all pipeline registers are flushed after a trap (legal 1..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the performance counters.
REQ-003 SHALL have ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- ID_rs1, ID_rs2  in  5 each  source register indices of the instruction in ID.
- ID_uses_rs1, ID_uses_rs2  in  1 each  ID instruction reads that register.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_memory_read  in  1  instruction in EX is a load.
- EX_redirect  in  1  branch mispredict or jump resolved in EX.
- trap_taken  in  1  trap or exception is committing this cycle.
- dmem_busy  in  1  data memory is not ready; MEM cannot complete.
- pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each  hold-register commands.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush  out  1 each  NOP-insertion commands.
- stall_cycle_count, flush_event_count  out  CNT_WIDTH each  performance counters.

Function
REQ-004 SHALL implement an FSM with the states RUN, MEM_WAIT and TRAP_FLUSH, plus a 4-bit flush counter.
REQ-005 SHALL decode outputs combinationally from the current state and inputs (Mealy), so a command takes effect at the clock edge that ends the detecting cycle.
REQ-006 SHALL define load_use = EX_memory_read AND EX_rd != 0 AND ((ID_uses_rs1 AND EX_rd == ID_rs1) OR (ID_uses_rs2 AND EX_rd == ID_rs2)).
REQ-007 SHALL, in RUN, apply this fixed priority: trap_taken > dmem_busy > EX_redirect > load_use; only the highest-priority active condition drives outputs.
REQ-008 On trap_taken in RUN: all three flushes = 1 and all stalls = 0; next state is TRAP_FLUSH with counter = TRAP_FLUSH_CYCLES-1, or RUN if TRAP_FLUSH_CYCLES == 1.
REQ-009 On dmem_busy in RUN: all four stalls = 1 and all flushes = 0; next state is MEM_WAIT.
REQ-010 On EX_redirect in RUN: IF_ID_flush = ID_EX_flush = 1 and all else = 0; next state is RUN.
REQ-011 On load_use in RUN: pc_stall = IF_ID_stall = 1 and ID_EX_flush = 1 (one bubble) and all else = 0; next state is RUN.
REQ-012 In MEM_WAIT while dmem_busy = 1: all four stalls = 1; EX_redirect and load_use are ignored.
REQ-013 In MEM_WAIT when dmem_busy = 0: outputs are evaluated exactly as in RUN that same cycle, and next state follows RUN rules.
REQ-014 trap_taken in MEM_WAIT SHALL override the wait: outputs and next state are as in REQ-008.
REQ-015 In TRAP_FLUSH: all three flushes = 1 and all stalls = 0, regardless of the other inputs.
- Counter decrements each cycle; at 0 the next state is RUN.
- trap_taken in TRAP_FLUSH reloads the counter to TRAP_FLUSH_CYCLES-1.
REQ-016 SHALL never assert the stall and flush of the same register in the same cycle.

Reset
REQ-017 While reset = 1: all stalls = 0 and all flushes = 1.
REQ-018 At a clock edge with reset = 1: state becomes RUN, flush counter becomes 0, and both performance counters become 0.
REQ-019 Reset mid-TRAP_FLUSH or mid-MEM_WAIT SHALL abandon the sequence with no residual state.

Configuration
REQ-020 With HAZARD_PERF_COUNTER_EN defined, the performance counters SHALL operate as follows:
- stall_cycle_count increments on every non-reset cycle with pc_stall = 1.
- flush_event_count increments on every non-reset cycle in which REQ-008 or REQ-010 fires.
- Both counters saturate at all-ones.
REQ-021 Without HAZARD_PERF_COUNTER_EN, both counter ports SHALL remain present and SHALL be tied to 0, with no counter flops.

Verification
REQ-022 The bench SHALL cover at least the following directed scenarios:
- Load-use: EX_memory_read = 1, EX_rd = 5, ID_rs2 = 5, ID_uses_rs2 = 1 -> pc_stall = IF_ID_stall = ID_EX_flush = 1 for exactly one cycle. With EX_rd = 0 -> no stall.
- Memory wait: dmem_busy high for 3 cycles -> all four stalls = 1 for 3 cycles. stall_cycle_count = 3 with macro defined, 0 without.
- Trap priority: trap_taken, dmem_busy and EX_redirect all high in one cycle -> three flushes for 2 cycles (default parameter), then return to RUN.
- Trap retrigger: trap_taken again in the 2nd TRAP_FLUSH cycle -> flushing extends to 3 total cycles.
- Redirect during a load-use condition -> IF_ID_flush = ID_EX_flush = 1, no stall, and flush_event_count increments by 1.
- Reset asserted mid-MEM_WAIT -> next cycle is in RUN with counters 0; flushes = 1 and stalls = 0 while reset is high.

Source files
------------

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller; optional perf counters under HAZARD_PERF_COUNTER_EN
module hazard_control_unit #(
  parameter int TRAP_FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ID_rs1,
  input  logic [4:0]           ID_rs2,
  input  logic                 ID_uses_rs1,
  input  logic                 ID_uses_rs2,
  input  logic [4:0]           EX_rd,
  input  logic                 EX_memory_read,
  input  logic                 EX_redirect,
  input  logic                 trap_taken,
  input  logic                 dmem_busy,
  output logic                 pc_stall,
  output logic                 IF_ID_stall,
  output logic                 ID_EX_stall,
  output logic                 EX_MEM_stall,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_flush,
  output logic                 EX_MEM_flush,
  output logic [CNT_WIDTH-1:0] stall_cycle_count,
  output logic [CNT_WIDTH-1:0] flush_event_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    TRAP_FLUSH = 2'd2
  } state_t;

  // Remaining TRAP_FLUSH cycles after the trap cycle itself
  localparam logic [3:0] RELOAD = 4'(TRAP_FLUSH_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       load_use;

  assign load_use = EX_memory_read && (EX_rd != 5'd0) &&
                    ((ID_uses_rs1 && (EX_rd == ID_rs1)) ||
                     (ID_uses_rs2 && (EX_rd == ID_rs2)));

  // State and flush-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Mealy decode: MEM_WAIT shares RUN's priority chain, which already stalls on dmem_busy
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    next_state   = state;
    next_cnt     = cnt;
    if (reset) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
      next_state   = RUN;
      next_cnt     = 4'd0;
    end else begin
      case (state)
        TRAP_FLUSH: begin
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
          if (trap_taken) begin
            next_cnt   = RELOAD;
            next_state = (RELOAD == 4'd0) ? RUN : TRAP_FLUSH;
          end else if (cnt <= 4'd1) begin
            next_cnt   = 4'd0;
            next_state = RUN;
          end else begin
            next_cnt   = cnt - 4'd1;
          end
        end
        default: begin
          next_state = RUN;
          if (trap_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            next_cnt     = RELOAD;
            next_state   = (RELOAD == 4'd0) ? RUN : TRAP_FLUSH;
          end else if (dmem_busy) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            next_state   = MEM_WAIT;
          end else if (EX_redirect) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_flush  = 1'b1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTER_EN
  logic                 flush_event;
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // A counted flush event is a trap accepted outside TRAP_FLUSH or a redirect that wins priority
  assign flush_event = !reset && (state != TRAP_FLUSH) &&
                       (trap_taken || (!dmem_busy && EX_redirect));

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_event && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycle_count = stall_q;
  assign flush_event_count = flush_q;
`else
  assign stall_cycle_count = '0;
  assign flush_event_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized and directed bench for hazard_control_unit
module tb_hazard_control_unit;
  localparam int TFC = 2;
  localparam int CW  = 32;
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_TRAP  = 7'b0000111;
  localparam logic [6:0] O_MEM   = 7'b1111000;
  localparam logic [6:0] O_REDIR = 7'b0000110;
  localparam logic [6:0] O_LU    = 7'b1100010;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ID_rs1, ID_rs2, EX_rd;
  logic          ID_uses_rs1, ID_uses_rs2, EX_memory_read, EX_redirect, trap_taken, dmem_busy;
  logic          pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
  logic          IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [CW-1:0] stall_cycle_count, flush_event_count;
  logic [6:0]    got;

  int          passed = 0;
  int          total  = 0;
  int          m_left;
  longint      m_stall, m_flush;
  logic [6:0]  exp_out;
  bit          exp_ev;
  int          exp_left;

  hazard_control_unit #(.TRAP_FLUSH_CYCLES(TFC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_memory_read(EX_memory_read), .EX_redirect(EX_redirect),
    .trap_taken(trap_taken), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .stall_cycle_count(stall_cycle_count),
    .flush_event_count(flush_event_count)
  );

  always #5 clk = ~clk;

  assign got = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, EX_MEM_flush};

  function automatic logic [CW-1:0] exp_stall_cnt();
`ifdef HAZARD_PERF_COUNTER_EN
    return m_stall[CW-1:0];
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] exp_flush_cnt();
`ifdef HAZARD_PERF_COUNTER_EN
    return m_flush[CW-1:0];
`else
    return '0;
`endif
  endfunction

  // Reference: remaining forced-flush cycles plus priority rules; MEM_WAIT needs no memory of its own
  task automatic predict();
    bit lu;
    lu = EX_memory_read && (EX_rd != 0) &&
         ((ID_uses_rs1 && EX_rd == ID_rs1) || (ID_uses_rs2 && EX_rd == ID_rs2));
    exp_ev = 0;
    exp_left = 0;
    if (reset) exp_out = O_TRAP;
    else if (m_left > 0) begin
      exp_out = O_TRAP;
      exp_left = trap_taken ? TFC - 1 : m_left - 1;
    end else if (trap_taken) begin
      exp_out = O_TRAP; exp_ev = 1; exp_left = TFC - 1;
    end else if (dmem_busy) exp_out = O_MEM;
    else if (EX_redirect) begin
      exp_out = O_REDIR; exp_ev = 1;
    end else if (lu) exp_out = O_LU;
    else exp_out = O_NONE;
  endtask

  task automatic drive(input bit rst, input bit trap, input bit busy, input bit redir,
                       input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u1, input bit u2);
    @(negedge clk);
    reset = rst; trap_taken = trap; dmem_busy = busy; EX_redirect = redir;
    EX_memory_read = mr; EX_rd = rd; ID_rs1 = rs1; ID_rs2 = rs2;
    ID_uses_rs1 = u1; ID_uses_rs2 = u2;
    #1;
    predict();
  endtask

  task automatic idle(input bit rst);
    drive(rst, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic tick();
    longint maxv;
    maxv = (longint'(1) << CW) - 1;
    @(posedge clk);
    if (reset) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_left = exp_left;
      if (exp_out[6] && m_stall < maxv) m_stall++;
      if (exp_ev && m_flush < maxv) m_flush++;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
    total++;
    if (got !== O_TRAP) $display("FAIL reset_outputs got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    idle(1);
    total++;
    if (got !== O_TRAP) $display("FAIL reset_outputs_idle got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    total++;
    if (stall_cycle_count !== '0 || flush_event_count !== '0)
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycle_count, flush_event_count);
    else passed++;
    idle(0);
    total++;
    if (got !== O_NONE) $display("FAIL run_idle got=%b exp=%b", got, O_NONE); else passed++;
    tick();
  endtask

  task automatic test_load_use();
    drive(0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
    total++;
    if (got !== O_LU) $display("FAIL load_use got=%b exp=%b", got, O_LU); else passed++;
    tick();
    idle(0);
    total++;
    if (got !== O_NONE) $display("FAIL load_use_one_cycle got=%b exp=%b", got, O_NONE); else passed++;
    tick();
    drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    total++;
    if (got !== O_NONE) $display("FAIL load_use_x0 got=%b exp=%b", got, O_NONE); else passed++;
    tick();
  endtask

  task automatic test_mem_wait();
    idle(1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, i == 1, 1, 5'd7, 5'd7, 5'd7, 1, 1);
      total++;
      if (got !== O_MEM) $display("FAIL mem_wait_%0d got=%b exp=%b", i, got, O_MEM); else passed++;
      tick();
    end
    idle(0);
    total++;
    if (got !== O_NONE) $display("FAIL mem_wait_release got=%b exp=%b", got, O_NONE); else passed++;
    total++;
`ifdef HAZARD_PERF_COUNTER_EN
    if (stall_cycle_count !== 32'd3) $display("FAIL mem_wait_count got=%0d exp=3", stall_cycle_count); else passed++;
`else
    if (stall_cycle_count !== 32'd0) $display("FAIL mem_wait_count got=%0d exp=0", stall_cycle_count); else passed++;
`endif
    tick();
  endtask

  task automatic test_trap_priority();
    drive(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    total++;
    if (got !== O_TRAP) $display("FAIL trap_prio_c0 got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    total++;
    if (got !== O_TRAP) $display("FAIL trap_prio_c1 got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    idle(0);
    total++;
    if (got !== O_NONE) $display("FAIL trap_prio_run got=%b exp=%b", got, O_NONE); else passed++;
    tick();
  endtask

  task automatic test_trap_retrigger();
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    total++;
    if (got !== O_TRAP) $display("FAIL retrig_c1 got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    idle(0);
    total++;
    if (got !== O_TRAP) $display("FAIL retrig_c2 got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    idle(0);
    total++;
    if (got !== O_NONE) $display("FAIL retrig_end got=%b exp=%b", got, O_NONE); else passed++;
    tick();
  endtask

  task automatic test_redirect_load_use();
    logic [CW-1:0] base;
    base = flush_event_count;
    drive(0, 0, 0, 1, 1, 5'd9, 5'd9, 5'd2, 1, 0);
    total++;
    if (got !== O_REDIR) $display("FAIL redir_lu got=%b exp=%b", got, O_REDIR); else passed++;
    tick();
    total++;
`ifdef HAZARD_PERF_COUNTER_EN
    if (flush_event_count !== base + 1'b1)
      $display("FAIL redir_count got=%0d exp=%0d", flush_event_count, base + 1'b1);
    else passed++;
`else
    if (flush_event_count !== '0 || base !== '0)
      $display("FAIL redir_count got=%0d exp=0", flush_event_count);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    total++;
    if (got !== O_MEM) $display("FAIL rst_wait_pre got=%b exp=%b", got, O_MEM); else passed++;
    tick();
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    total++;
    if (got !== O_TRAP) $display("FAIL rst_wait_during got=%b exp=%b", got, O_TRAP); else passed++;
    tick();
    drive(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0);
    total++;
    if (got !== O_LU || stall_cycle_count !== '0 || flush_event_count !== '0)
      $display("FAIL rst_wait_after got=%b cnt=%0d/%0d exp=%b cnt=0/0", got, stall_cycle_count, flush_event_count, O_LU);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      total++;
      if (got !== exp_out || (got[5] && got[2]) || (got[4] && got[1]) || (got[3] && got[0]))
        $display("FAIL rand_out_%0d got=%b exp=%b", i, got, exp_out);
      else passed++;
      tick();
      total++;
      if (stall_cycle_count !== exp_stall_cnt() || flush_event_count !== exp_flush_cnt())
        $display("FAIL rand_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, stall_cycle_count,
                 flush_event_count, exp_stall_cnt(), exp_flush_cnt());
      else passed++;
    end
  endtask

  initial begin
    m_left = 0; m_stall = 0; m_flush = 0;
    reset = 1; trap_taken = 0; dmem_busy = 0; EX_redirect = 0; EX_memory_read = 0;
    EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_trap_priority();
    test_trap_retrigger();
    test_redirect_load_use();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
